// File: rtl/force_release_target.sv
// Forceable WIDTH-bit signal with a force/release/read command port.
// Resolves driver, retained variable value and per-bit force overlay.
module force_release_target #(
    parameter int WIDTH = 64,
    parameter bit IS_NET = 1'b0,
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drv_valid,
    input  logic [WIDTH-1:0] drv_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_lsb,
    input  logic [AW-1:0]    cmd_msb,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [WIDTH-1:0] value_o,
    output logic [WIDTH-1:0] fmask_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_RESP
    } state_e;

    localparam logic [1:0] OP_FORCE   = 2'd0;
    localparam logic [1:0] OP_RELEASE = 2'd1;
    localparam logic [1:0] OP_READ    = 2'd2;
    localparam logic [1:0] OP_ILL     = 2'd3;

    localparam logic [WIDTH-1:0] ONES   = '1;
    localparam logic [AW:0]      MAXIDX = (AW + 1)'(WIDTH - 1);

    state_e state_q, state_d;

    logic [1:0]       op_q, op_d;
    logic [AW-1:0]    lsb_q, lsb_d;
    logic [AW-1:0]    msb_q, msb_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic [WIDTH-1:0] fmask_q, fmask_d;
    logic [WIDTH-1:0] fval_q, fval_d;
    logic [WIDTH-1:0] var_q, var_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [AW:0]      hi_sh;
    logic [WIDTH-1:0] range_m;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] rel_m;
    logic [WIDTH-1:0] base;
    logic             cmd_err;

    assign cmd_ready = (state_q == S_IDLE);

    assign hi_sh   = MAXIDX - {1'b0, msb_q};
    assign range_m = (ONES << lsb_q) & (ONES >> hi_sh);
    assign shifted = (data_q << lsb_q) & range_m;

    assign cmd_err = (msb_q < lsb_q)
                  || (op_q == OP_ILL)
                  || ({1'b0, msb_q} > MAXIDX);

    // Only bits that were actually forced carry a held value back.
    assign rel_m = range_m & fmask_q;

    assign base    = IS_NET ? drv_data : var_q;
    assign value_o = (fmask_q & fval_q) | (~fmask_q & base);
    assign fmask_o = fmask_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lsb_d       = lsb_q;
        msb_d       = msb_q;
        data_d      = data_q;
        fmask_d     = fmask_q;
        fval_d      = fval_q;
        var_d       = var_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    lsb_d   = cmd_lsb;
                    msb_d   = cmd_msb;
                    data_d  = cmd_data;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = cmd_err;
                rsp_data_d  = '0;
                if (!cmd_err) begin
                    unique case (op_q)
                        OP_FORCE: begin
                            fmask_d = fmask_q | range_m;
                            fval_d  = (fval_q & ~range_m) | shifted;
                        end
                        OP_RELEASE: begin
                            fmask_d = fmask_q & ~range_m;
                            if (!IS_NET) begin
                                var_d = (var_q & ~rel_m) | (fval_q & rel_m);
                            end
                        end
                        OP_READ: begin
                            rsp_data_d = value_o;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Driver write lands after any same-cycle release, so it wins there.
        if (!IS_NET && drv_valid) begin
            var_d = (drv_data & ~fmask_d) | (var_d & fmask_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            lsb_q       <= '0;
            msb_q       <= '0;
            data_q      <= '0;
            fmask_q     <= '0;
            fval_q      <= '0;
            var_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lsb_q       <= lsb_d;
            msb_q       <= msb_d;
            data_q      <= data_d;
            fmask_q     <= fmask_d;
            fval_q      <= fval_d;
            var_q       <= var_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_force_release_target.sv
// Bench for force_release_target: variable and net instances side by side,
// per-bit reference model, response scoreboard, directed plus random commands.
module tb_force_release_target;

    localparam int W = 64;

    localparam logic [1:0] FORCE = 2'd0;
    localparam logic [1:0] RELEASE = 2'd1;
    localparam logic [1:0] READ = 2'd2;

    localparam logic [W-1:0] PA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [W-1:0] P5 = 64'h5555_5555_5555_5555;
    localparam logic [W-1:0] MIX = 64'hAAAA_AAAA_5555_5555;
    localparam logic [W-1:0] LOWM = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drv_valid = 1'b0;
    logic [W-1:0] drv_data = '0;
    logic cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [5:0] cmd_lsb = '0;
    logic [5:0] cmd_msb = '0;
    logic [W-1:0] cmd_data = '0;
    logic rsp_ready = 1'b0;

    logic cmd_ready [2];
    logic rsp_valid [2];
    logic rsp_err [2];
    logic [W-1:0] rsp_data [2];
    logic [W-1:0] value_o [2];
    logic [W-1:0] fmask_o [2];

    always #5 clk = ~clk;

    force_release_target #(.WIDTH(W), .IS_NET(1'b0)) u_var (
        .clk(clk), .rst(rst),
        .drv_valid(drv_valid), .drv_data(drv_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op), .cmd_lsb(cmd_lsb), .cmd_msb(cmd_msb),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .value_o(value_o[0]), .fmask_o(fmask_o[0])
    );

    force_release_target #(.WIDTH(W), .IS_NET(1'b1)) u_net (
        .clk(clk), .rst(rst),
        .drv_valid(drv_valid), .drv_data(drv_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op), .cmd_lsb(cmd_lsb), .cmd_msb(cmd_msb),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .value_o(value_o[1]), .fmask_o(fmask_o[1])
    );

    typedef struct {
        logic [W-1:0] data;
        logic err;
    } rsp_t;

    // Reference model: per-bit forced flag, forced value and held value.
    bit [W-1:0] m_forced [2];
    bit [W-1:0] m_fv [2];
    bit [W-1:0] m_vv [2];
    rsp_t exq [2][$];
    int mph = 0;
    logic [1:0] l_op = 2'd0;
    int l_lsb = 0;
    int l_msb = 0;
    logic [W-1:0] l_data = '0;

    int nchk = 0;
    int nfail = 0;
    bit rand_drv = 1'b0;

    function automatic logic [W-1:0] eff(int k, logic [W-1:0] drv);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            if (m_forced[k][i]) r[i] = m_fv[k][i];
            else if (k == 1) r[i] = drv[i];
            else r[i] = m_vv[k][i];
        end
        return r;
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : model
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < 2; k++) begin
                    m_forced[k] = '0;
                    m_fv[k] = '0;
                    m_vv[k] = '0;
                    exq[k].delete();
                end
                mph = 0;
            end else begin
                if (mph == 0) begin
                    if (cmd_valid) begin
                        l_op = cmd_op;
                        l_lsb = int'(cmd_lsb);
                        l_msb = int'(cmd_msb);
                        l_data = cmd_data;
                        mph = 1;
                    end
                end else if (mph == 1) begin
                    for (int k = 0; k < 2; k++) begin
                        rsp_t r;
                        logic [W-1:0] rd;
                        rd = eff(k, drv_data);
                        r.err = (l_msb < l_lsb) || (l_op == 2'd3);
                        r.data = (!r.err && l_op == READ) ? rd : '0;
                        if (!r.err) begin
                            for (int i = l_lsb; i <= l_msb; i++) begin
                                if (l_op == FORCE) begin
                                    m_forced[k][i] = 1'b1;
                                    m_fv[k][i] = l_data[i - l_lsb];
                                end else if (l_op == RELEASE) begin
                                    if (m_forced[k][i] && k == 0)
                                        m_vv[k][i] = m_fv[k][i];
                                    m_forced[k][i] = 1'b0;
                                end
                            end
                        end
                        exq[k].push_back(r);
                    end
                    mph = 2;
                end else begin
                    if (rsp_ready) mph = 0;
                end
                if (drv_valid) begin
                    for (int i = 0; i < W; i++)
                        if (!m_forced[0][i]) m_vv[0][i] = drv_data[i];
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("value_o[%0d]", k), value_o[k], eff(k, drv_data));
                chk($sformatf("fmask_o[%0d]", k), fmask_o[k], m_forced[k]);
                chk($sformatf("cmd_ready[%0d]", k),
                    W'(cmd_ready[k]), W'(mph == 0));
                chk($sformatf("rsp_valid[%0d]", k),
                    W'(rsp_valid[k]), W'(mph == 2));
                if (rsp_valid[k]) begin
                    if (exq[k].size() == 0) begin
                        chk($sformatf("rsp_unexpected[%0d]", k), 64'd1, 64'd0);
                    end else begin
                        chk($sformatf("rsp_data[%0d]", k),
                            rsp_data[k], exq[k][0].data);
                        chk($sformatf("rsp_err[%0d]", k),
                            W'(rsp_err[k]), W'(exq[k][0].err));
                        if (rsp_ready) void'(exq[k].pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_drv) begin
            drv_valid = 1'($urandom_range(0, 1));
            drv_data = {$urandom, $urandom};
        end
    endtask

    task automatic issue(logic [1:0] op, int msb, int lsb, logic [W-1:0] d);
        int n;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_msb = 6'(msb);
        cmd_lsb = 6'(lsb);
        cmd_data = d;
        for (n = 0; n < 20; n++) begin
            tick();
            if (mph == 1) break;
        end
        if (n == 20) chk("accept_timeout", 64'd1, 64'd0);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp(int stall);
        int n;
        rsp_ready = 1'b0;
        repeat (stall) tick();
        rsp_ready = 1'b1;
        for (n = 0; n < 20; n++) begin
            tick();
            if (mph == 0) break;
        end
        if (n == 20) chk("rsp_timeout", 64'd1, 64'd0);
        rsp_ready = 1'b0;
    endtask

    task automatic chk_reset(logic [W-1:0] net_drv);
        chk("rst value_o[0]", value_o[0], '0);
        chk("rst value_o[1]", value_o[1], net_drv);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst fmask_o[%0d]", k), fmask_o[k], '0);
            chk($sformatf("rst cmd_ready[%0d]", k), W'(cmd_ready[k]), 64'd1);
            chk($sformatf("rst rsp_valid[%0d]", k), W'(rsp_valid[k]), 64'd0);
            chk($sformatf("rst rsp_err[%0d]", k), W'(rsp_err[k]), 64'd0);
            chk($sformatf("rst rsp_data[%0d]", k), rsp_data[k], '0);
        end
    endtask

    initial begin : stim
        rst = 1'b1;
        tick();
        tick();
        chk_reset('0);
        rst = 1'b0;
        tick();

        drv_valid = 1'b1;
        drv_data = PA;
        tick();
        drv_valid = 1'b0;
        issue(FORCE, 63, 0, P5);
        tick();
        chk("full force value[0]", value_o[0], P5);
        chk("full force value[1]", value_o[1], P5);
        chk("full force fmask[0]", fmask_o[0], '1);
        chk("full force err[0]", W'(rsp_err[0]), 64'd0);
        finish_rsp(0);

        issue(RELEASE, 63, 0, '0);
        tick();
        chk("var release holds", value_o[0], P5);
        chk("net release reverts", value_o[1], PA);
        finish_rsp(0);
        drv_valid = 1'b1;
        drv_data = PA;
        tick();
        drv_valid = 1'b0;
        chk("var drv after release", value_o[0], PA);

        issue(FORCE, 31, 0, 64'h0000_0000_5555_5555);
        tick();
        chk("partial force value", value_o[0], MIX);
        finish_rsp(1);
        issue(READ, 0, 0, '0);
        tick();
        chk("read data", rsp_data[0], MIX);
        finish_rsp(0);

        issue(FORCE, 3, 7, '1);
        tick();
        chk("msb<lsb err", W'(rsp_err[0]), 64'd1);
        chk("msb<lsb fmask", fmask_o[0], LOWM);
        chk("msb<lsb value", value_o[0], MIX);
        finish_rsp(0);
        issue(2'd3, 63, 0, '1);
        tick();
        chk("op3 err", W'(rsp_err[1]), 64'd1);
        chk("op3 fmask", fmask_o[1], LOWM);
        chk("op3 value", value_o[0], MIX);
        finish_rsp(0);

        issue(READ, 63, 0, '0);
        rsp_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("stall cmd_ready", W'(cmd_ready[0]), 64'd0);
            chk("stall rsp_valid", W'(rsp_valid[0]), 64'd1);
            chk("stall rsp_data", rsp_data[0], MIX);
        end
        rst = 1'b1;
        tick();
        chk_reset(PA);
        rst = 1'b0;
        tick();

        rand_drv = 1'b1;
        repeat (300) begin
            int r;
            int lsb;
            int msb;
            logic [1:0] op;
            r = int'($urandom_range(0, 9));
            op = (r < 4) ? FORCE : (r < 7) ? RELEASE : (r < 9) ? READ : 2'd3;
            lsb = int'($urandom_range(0, 63));
            if ($urandom_range(0, 9) != 0)
                msb = int'($urandom_range(lsb, 63));
            else
                msb = int'($urandom_range(0, 63));
            issue(op, msb, lsb, {$urandom, $urandom});
            finish_rsp(int'($urandom_range(0, 3)));
        end
        rand_drv = 1'b0;
        drv_valid = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
